// File: rtl/datamem_pkg.sv
// Shared types and default widths for the datamem arbiter slice.
package datamem_pkg;

    localparam int unsigned DATAMEM_ADDR_W = 8;
    localparam int unsigned DATAMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

endpackage

// File: rtl/datamem_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the port not granted last wins.
module datamem_rr_pick
    import datamem_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_id    = REQ_A;
        if (req_a && req_b) begin
            grant_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            grant_id = REQ_B;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Shares the single-port datamem between port A (core) and port B (loader/debug);
// one access per grant, IDLE -> ACCESS -> RESP.
module datamem_arbiter
    import datamem_pkg::*;
#(
    parameter int unsigned ADDR_W = DATAMEM_ADDR_W,
    parameter int unsigned DATA_W = DATAMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    req_id_t           r_last_grant;
    req_id_t           r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_grant_valid;
    req_id_t           w_grant_id;
    logic              w_grant;
    logic              w_rd_done;

    datamem_rr_pick u_pick (
        .req_a       (a_req),
        .req_b       (b_req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // Requests are only looked at in IDLE, so a held req cannot be served twice.
    assign w_grant   = (r_state == IDLE) && w_grant_valid;
    assign w_rd_done = (r_state == ACCESS) && !r_we;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant_valid) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= REQ_B;
            r_id         <= REQ_A;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_grant_id;
            r_id         <= w_grant_id;
            if (w_grant_id == REQ_A) begin
                r_we    <= a_we;
                r_addr  <= a_addr;
                r_wdata <= a_wdata;
            end else begin
                r_we    <= b_we;
                r_addr  <= b_addr;
                r_wdata <= b_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if (w_rd_done) begin
            if (r_id == REQ_A) begin
                r_a_rdata <= mem_rdata;
            end else begin
                r_b_rdata <= mem_rdata;
            end
        end
    end

    // Decoded from state so an async reset drops mem_we before the next edge.
    assign mem_we    = (r_state == ACCESS) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign a_ack     = (r_state == RESP) && (r_id == REQ_A);
    assign b_ack     = (r_state == RESP) && (r_id == REQ_B);
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign busy      = (r_state != IDLE);

endmodule
